// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter and the BUS address decoder.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

  // Slave address windows, shared with the BUS decoder.
  localparam logic [15:0] S0_BASE = 16'h0000;
  localparam logic [15:0] S0_LAST = 16'h07FF;
  localparam logic [15:0] S1_BASE = 16'h7000;
  localparam logic [15:0] S1_LAST = 16'h71FF;

endpackage

// File: rtl/bus_arbiter_hold_counter.sv
// Saturating up-counter with synchronous clear and enable; tracks how long the owner has held the bus.
module hold_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with grant hold and optional forced handover under contention.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m_sel,
  output logic              bus_busy,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit                FORCE_EN  = (MAX_HOLD != 0);

  state_t state;
  state_t state_nx;
  logic   last_owner;
  logic   force_c;
  logic   cnt_clear;
  logic   cnt_enable;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    force_c  = FORCE_EN && m0_req && m1_req && (hold_cnt == HOLD_LAST);
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_nx = (last_owner == SEL_M0) ? ST_GRANT1 : ST_GRANT0;
        end else if (m0_req) begin
          state_nx = ST_GRANT0;
        end else if (m1_req) begin
          state_nx = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!m0_req) begin
          state_nx = m1_req ? ST_GRANT1 : ST_IDLE;
        end else if (force_c) begin
          state_nx = ST_GRANT1;
        end
      end
      ST_GRANT1: begin
        if (!m1_req) begin
          state_nx = m0_req ? ST_GRANT0 : ST_IDLE;
        end else if (force_c) begin
          state_nx = ST_GRANT0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant decode from the registered state
  always_comb begin
    m0_grant = (state == ST_GRANT0);
    m1_grant = (state == ST_GRANT1);
    bus_busy = (state == ST_GRANT0) || (state == ST_GRANT1);
  end

  // m_sel and last_owner only move on grant entry, so the mux holds steady through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= SEL_M1;
      m_sel      <= SEL_M0;
    end else begin
      case (state_nx)
        ST_GRANT0: begin
          last_owner <= SEL_M0;
          m_sel      <= SEL_M0;
        end
        ST_GRANT1: begin
          last_owner <= SEL_M1;
          m_sel      <= SEL_M1;
        end
        default: ;
      endcase
    end
  end

  assign cnt_clear  = (state_nx != state) || (state == ST_IDLE);
  assign cnt_enable = (state != ST_IDLE);

  hold_counter #(
    .W(HOLD_W)
  ) u_hold_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .cnt   (hold_cnt)
  );

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter placed in front of the shared BUS datapath (decode s0 0x0000–0x07FF, s1 0x7000–0x71FF).
- Takes per-master request lines and issues registered, mutually exclusive grants.
- Drives the master-select used by the BUS muxes.
- Policy: round-robin between simultaneous requesters, grant held while the owner keeps requesting, optional forced handover after MAX_HOLD cycles of contention.

Parameters:
- HOLD_W, 8, width of hold counter.
- MAX_HOLD, 16, contended cycles before forced handover; 0 disables forced handover; must be < 2^HOLD_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 requests bus.
- m1_req  input  1  master 1 requests bus.
- m0_grant  output  1  master 0 owns bus (registered).
- m1_grant  output  1  master 1 owns bus (registered).
- m_sel  output  1  BUS master mux select: 0 = m0, 1 = m1 (registered).
- bus_busy  output  1  m0_grant | m1_grant.
- hold_cnt  output  HOLD_W  cycles current owner has held grant; debug/verification.

Behaviour:
- All state updates on rising clk only. reset=1 at an edge overrides everything.
- Reset values:
  - state=IDLE; m0_grant=0; m1_grant=0; m_sel=0; hold_cnt=0.
  - last_owner=1, so m0 wins the first tie.
- States: IDLE, GRANT0, GRANT1 (one-hot or 2-bit encoding, implementer's choice). Grants decoded from registered state; never both 1.
- Latency: request sampled at edge k → grant high after edge k. Request drop sampled at edge k → grant low after edge k.
- IDLE:
  - both req → GRANT to master != last_owner.
  - m0 only → GRANT0.
  - m1 only → GRANT1.
  - none → IDLE.
- GRANT0:
  - m0_req=0 and m1_req=1 → GRANT1 directly (no IDLE bubble).
  - m0_req=0 and m1_req=0 → IDLE.
  - m0_req=1 and m1_req=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 → GRANT1 (forced handover).
  - otherwise stay.
- GRANT1: symmetric.
- last_owner updates to the granted index on every entry to GRANT0/GRANT1.
- hold_cnt:
  - Cleared on any state change and in IDLE.
  - Increments each cycle the state is unchanged in GRANTx; saturates at 2^HOLD_W-1.
  - Counts whether or not the other master requests; forced handover requires contention at the threshold cycle.
- m_sel = 1 in GRANT1, 0 in GRANT0; holds its previous value in IDLE, so the datapath mux does not glitch.
- Reset mid-grant: grants drop after the reset edge. The first tie after reset goes to m0.
- Requests asserted during reset are ignored. They are evaluated at the first edge with reset=0.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE, ST_GRANT0, ST_GRANT1;
  - constants SEL_M0=0, SEL_M1=1;
  - address-map constants S0_BASE=16'h0000, S0_LAST=16'h07FF, S1_BASE=16'h7000, S1_LAST=16'h71FF (shared with BUS decoder).
- Sub-module: hold_counter (HOLD_W-bit saturating counter with clear and enable). All other logic lives in bus_arbiter.

Test Plan:
- Reset: reset=1 for 2 cycles with m0_req=m1_req=1 → m0_grant=m1_grant=0, m_sel=0, hold_cnt=0. Release reset → after next edge m0_grant=1, m_sel=0.
- Single master: m1_req=1 for 5 cycles then 0 → m1_grant high 1 edge after request, stays 5 cycles, m_sel=1. After drop, IDLE with m_sel still 1, bus_busy=0.
- Direct handover: GRANT0 held, m1_req=1, then m0_req falls at edge k → m1_grant=1 after edge k, m0_grant=0 same edge, never both high.
- Round-robin: both req from IDLE with last_owner=0 (after an m0-only transaction) → m1 granted first.
- Forced handover: MAX_HOLD=4, m0 owns, both held high → after 4 grant cycles ownership moves to m1. After 4 more it moves back to m0. hold_cnt sequence 0,1,2,3,0,…
- Disable/saturation: MAX_HOLD=0, HOLD_W=3, both req for 20 cycles → m0 keeps grant throughout, hold_cnt saturates at 7.
